udma_evt_collector: RTL and testbench
=====================================

// Module: udma_evt_collector
// PURPOSE
//  Upstream feeder of the uDMA control/event-compare stage. Collects single-cycle event pulses
//  from N_SRC peripheral channels, buffers them in per-source saturating pending counters, and
//  serialises them round-robin onto one 8-bit valid/ready event stream (ID = EVT_ID_BASE+source).
//  Output drives the event_valid/event_data/event_ready input of the uDMA control block.
// PARAMETERS
//  N_SRC        16  number of event sources; 1..256, N_SRC+EVT_ID_BASE <= 256
//  CNT_W        2   pending counter width per source; max pending = 2**CNT_W-1
//  EVT_ID_BASE  0   event ID emitted for source 0; source i emits EVT_ID_BASE+i
// PORTS
//  clk_i          in   1      clock; single clock domain
//  rstn_i         in   1      reset, synchronous, active-low
//  evt_i          in   N_SRC  event pulses; bit i high for one cycle = one event of source i
//  evt_mask_i     in   N_SRC  1 = source enabled; masked pulses are dropped (not counted)
//  event_valid_o  out  1      output event valid
//  event_data_o   out  8      output event ID
//  event_ready_i  in   1      downstream accepts event when high with event_valid_o
//  ovf_o          out  N_SRC  sticky per-source overflow flag
//  ovf_clr_i      in   N_SRC  1-cycle per-bit clear of ovf_o
//  pending_o      out  1      OR of all counters != 0 (any event buffered, excl. output reg)
// BEHAVIOUR
//  Reset (rstn_i low at clk edge): all counters 0, event_valid_o 0, event_data_o 0, ovf_o 0,
//   RR pointer 0, pending_o 0. Reset mid-operation discards buffered and in-flight events.
//  Counters: per source, each cycle:
//   inc = evt_i[i] & evt_mask_i[i]; dec = source i granted this cycle.
//   inc&dec -> unchanged; inc only -> +1 unless at max; dec only -> -1.
//   inc only at max -> counter stays max, ovf_o[i] set next cycle (event lost).
//   inc&dec at max -> unchanged, no overflow.
//  Output slot: single register. Slot is "free" when event_valid_o==0 or
//   (event_valid_o & event_ready_i). When free and any counter != 0: grant one source, load
//   event_data_o = EVT_ID_BASE+idx, event_valid_o=1, decrement that counter (same edge).
//   When free and all counters 0: event_valid_o <= 0.
//  Handshake: once asserted, event_valid_o and event_data_o hold stable until accepted.
//   Back-to-back transfers at 1 event/cycle when event_ready_i stays high.
//  Arbitration: uses registered counters only (a pulse in cycle t is not eligible in t).
//   Search order r_ptr, r_ptr+1, ... wrap at N_SRC-1 -> 0; first nonzero wins.
//   After grant of idx: r_ptr <= (idx==N_SRC-1) ? 0 : idx+1. No grant -> r_ptr unchanged.
//  Latency: pulse in cycle t with empty slot -> event_valid_o high in cycle t+2.
//  Mask: clearing evt_mask_i[i] only blocks new increments; pending events of i still drain.
//  ovf_o: set has priority over ovf_clr_i in the same cycle; ovf_clr_i clears only its bits.
//  pending_o is combinational from registered counters; no other combinational in->out path.
//  event_ready_i while event_valid_o==0 is ignored.
// TESTING
//  T1 single: evt_i[3] pulse cycle 0, ready=1 -> valid=1,data=0x03 in cycle 2, one cycle only.
//  T2 RR fairness: pulses on src 1,5,14 in same cycle, ready=1 -> IDs 0x01,0x05,0x0E on
//     consecutive cycles; then src 0 and 14 pulse -> order 0x00,0x0E (ptr wrapped from 15).
//  T3 backpressure: src 2 pulse, ready=0 for 10 cycles -> data=0x02 held stable, valid held;
//     ready=1 -> accepted once, valid drops next cycle, no duplicate.
//  T4 saturation: CNT_W=2, ready=0, 5 pulses on src 7 -> 1 in slot + counter 3, ovf_o[7]=1
//     after 5th pulse; ready=1 -> exactly 4 events 0x07; ovf_clr_i[7] -> ovf_o[7]=0.
//  T5 simultaneous inc/dec: src 4 counter at max while being granted and pulsed same cycle ->
//     counter stays max, ovf_o[4] stays 0; mask src 4 -> further pulses dropped, backlog drains.
//  T6 reset mid-stream: 3 pending sources, valid high, rstn_i low 1 cycle -> all outputs 0,
//     no stale events emitted after release; EVT_ID_BASE=0x20 run -> src 0 emits 0x20.

Source files
------------

// File: rtl/udma_evt_collector.sv
// Event collector for the uDMA control stage: per-source saturating pending counters,
// drained round-robin onto a single 8-bit valid/ready event stream.
module udma_evt_collector #(
  parameter int unsigned N_SRC       = 16,
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned EVT_ID_BASE = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_SRC-1:0] evt_i,
  input  logic [N_SRC-1:0] evt_mask_i,
  output logic             event_valid_o,
  output logic [7:0]       event_data_o,
  input  logic             event_ready_i,
  output logic [N_SRC-1:0] ovf_o,
  input  logic [N_SRC-1:0] ovf_clr_i,
  output logic             pending_o
);

  localparam int unsigned      PTR_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SRC - 1);
  localparam logic [7:0]       ID_BASE  = 8'(EVT_ID_BASE);

  logic [CNT_W-1:0] cnt_q [N_SRC];
  logic [CNT_W-1:0] cnt_d [N_SRC];
  logic [N_SRC-1:0] cnt_nz;
  logic [N_SRC-1:0] inc_vec;
  logic [N_SRC-1:0] dec_vec;
  logic [N_SRC-1:0] ovf_q;
  logic [N_SRC-1:0] ovf_d;
  logic [PTR_W-1:0] r_ptr_q;
  logic             valid_q;
  logic [7:0]       data_q;
  logic             slot_free;
  logic             gnt_found;
  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) cnt_nz[i] = (cnt_q[i] != '0);
  end

  assign inc_vec   = evt_i & evt_mask_i;
  assign slot_free = ~valid_q | event_ready_i;
  assign gnt_vld   = slot_free & gnt_found;

  // Round-robin search starting at r_ptr_q; only registered counters are eligible,
  // so a pulse arriving this cycle cannot be granted before the next one.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int cand;
      cand = int'(r_ptr_q) + k;
      if (cand >= int'(N_SRC)) cand = cand - int'(N_SRC);
      if (!gnt_found && cnt_nz[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

  // Saturating counters: a simultaneous increment and grant cancel out, even at max,
  // so overflow is only flagged when an event really has nowhere to go.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      dec_vec[i] = gnt_vld && (gnt_idx == PTR_W'(i));
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = ovf_q[i] & ~ovf_clr_i[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      // NOTE: the counter array is reset explicitly; stale counts would replay discarded events.
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
      ovf_q   <= '0;
      r_ptr_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (slot_free) begin
        valid_q <= gnt_found;
        if (gnt_found) begin
          data_q  <= ID_BASE + 8'(gnt_idx);
          r_ptr_q <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign event_valid_o = valid_q;
  assign event_data_o  = data_q;
  assign ovf_o         = ovf_q;
  assign pending_o     = |cnt_nz;

endmodule

// File: tb/tb_udma_evt_collector.sv
// Self-checking bench for udma_evt_collector: scoreboard of expected event IDs popped on
// each accepted handshake, plus direct checks of latency, backpressure, saturation and reset.
module tb_udma_evt_collector;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] evt, mask, ovf, ovf_clr;
  logic         valid, ready, pending;
  logic [7:0]   data;

  logic [N-1:0] evt_b, ovf_b;
  logic         valid_b, ready_b, pending_b;
  logic [7:0]   data_b;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  udma_evt_collector #(.N_SRC(N), .CNT_W(2), .EVT_ID_BASE(0)) dut (
    .clk_i(clk), .rstn_i(rstn), .evt_i(evt), .evt_mask_i(mask),
    .event_valid_o(valid), .event_data_o(data), .event_ready_i(ready),
    .ovf_o(ovf), .ovf_clr_i(ovf_clr), .pending_o(pending)
  );

  udma_evt_collector #(.N_SRC(N), .CNT_W(2), .EVT_ID_BASE(32'h20)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .evt_i(evt_b), .evt_mask_i({N{1'b1}}),
    .event_valid_o(valid_b), .event_data_o(data_b), .event_ready_i(ready_b),
    .ovf_o(ovf_b), .ovf_clr_i({N{1'b0}}), .pending_o(pending_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check({tag, "_drained"}, sb_q.size(), 0);
  endtask

  // Every accepted handshake must match the oldest expected ID.
  always @(negedge clk) begin
    if (rstn === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      if (sb_q.size() == 0) check("sb_unexpected", sb_q.size(), 1);
      else                  check("sb_id", data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn = 1'b0; evt = '0; mask = '1; ready = 1'b0; ovf_clr = '0;
    evt_b = '0; ready_b = 1'b1;
    step(2);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_pending", pending, 0);
    check("rst_valid_b", valid_b, 0);
    rstn = 1'b1;
    step();

    // T2: round-robin order from pointer 0, then wrap from pointer 15
    ready = 1'b1;
    evt = (16'h1 << 1) | (16'h1 << 5) | (16'h1 << 14);
    sb_q.push_back(8'h01); sb_q.push_back(8'h05); sb_q.push_back(8'h0E);
    step(); evt = '0;
    check("t2_pending", pending, 1);
    check("t2_lat_valid", valid, 0);
    step(); check("t2_v0", valid, 1); check("t2_d0", data, 8'h01);
    step(); check("t2_v1", valid, 1); check("t2_d1", data, 8'h05);
    step(); check("t2_v2", valid, 1); check("t2_d2", data, 8'h0E);
    step(); check("t2_idle", valid, 0);
    evt = (16'h1 << 0) | (16'h1 << 14);
    sb_q.push_back(8'h00); sb_q.push_back(8'h0E);
    step(); evt = '0;
    step(); check("t2_wrap_d0", data, 8'h00);
    step(); check("t2_wrap_d1", data, 8'h0E);
    step(); check("t2_wrap_idle", valid, 0);

    // T1: single event, two-cycle latency, one cycle of valid
    evt = 16'h1 << 3; sb_q.push_back(8'h03);
    step(); evt = '0;
    check("t1_lat", valid, 0);
    step(); check("t1_valid", valid, 1); check("t1_data", data, 8'h03);
    step(); check("t1_drop", valid, 0); check("t1_pending", pending, 0);

    // T3: backpressure holds the slot stable
    ready = 1'b0;
    evt = 16'h1 << 2; sb_q.push_back(8'h02);
    step(); evt = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", valid, 1);
      check("t3_hold_data", data, 8'h02);
      step();
    end
    ready = 1'b1;
    step();
    check("t3_after_valid", valid, 0);
    check("t3_sb_empty", sb_q.size(), 0);

    // T4: saturation on src 7 with overflow, drain, clear
    ready = 1'b0;
    evt = 16'h1 << 7;
    for (int p = 0; p < 5; p++) begin
      step();
      if (p == 3) check("t4_no_ovf_yet", ovf[7], 0);
    end
    evt = '0;
    check("t4_ovf", ovf[7], 1);
    check("t4_pending", pending, 1);
    check("t4_slot", data, 8'h07);
    repeat (4) sb_q.push_back(8'h07);
    ready = 1'b1;
    drain("t4", 20);
    check("t4_idle", valid, 0);
    check("t4_ovf_sticky", ovf[7], 1);
    ovf_clr = 16'h1 << 7;
    step(); ovf_clr = '0;
    check("t4_ovf_clr", ovf[7], 0);

    // T5: inc and grant at max cancel; masked pulses dropped while backlog drains
    ready = 1'b0;
    evt = 16'h1 << 4;
    step(4);
    check("t5_slot", data, 8'h04);
    repeat (5) sb_q.push_back(8'h04);
    ready = 1'b1;
    step();
    check("t5_no_ovf", ovf[4], 0);
    mask[4] = 1'b0;
    drain("t5", 20);
    evt = '0;
    check("t5_no_ovf_end", ovf[4], 0);
    check("t5_idle", valid, 0);
    mask = '1;

    // T6: reset mid-stream discards everything
    ready = 1'b0;
    evt = 16'h1 << 9;
    step(5);
    evt = (16'h1 << 1) | (16'h1 << 2) | (16'h1 << 3);
    step(); evt = '0;
    step();
    check("t6_pre_ovf", ovf[9], 1);
    check("t6_pre_valid", valid, 1);
    rstn = 1'b0;
    sb_q.delete();
    step();
    rstn = 1'b1;
    check("t6_valid", valid, 0);
    check("t6_data", data, 0);
    check("t6_ovf", ovf, 0);
    check("t6_pending", pending, 0);
    ready = 1'b1;
    step(10);
    check("t6_no_stale", valid, 0);
    check("t6_pending_end", pending, 0);

    // EVT_ID_BASE offset instance
    evt_b = 16'h1;
    step(); evt_b = '0;
    step(); check("base_valid", valid_b, 1); check("base_id0", data_b, 8'h20);
    step(); check("base_drop", valid_b, 0);
    evt_b = 16'h1 << 5;
    step(); evt_b = '0;
    step(); check("base_id5", data_b, 8'h25);
    step(); check("base_pending", pending_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
